// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and data-bit clamp.
// Used by uart_rx_cfg (optional 2-of-3 sampling: UART_RX_MAJORITY_EN).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam logic [3:0] DBIT_MIN = 4'd5;

    function automatic logic [3:0] clamp_dbits(input logic [3:0] i_req, input logic [3:0] i_max);
        if (i_req < DBIT_MIN)
            return DBIT_MIN;
        else if (i_req > i_max)
            return i_max;
        else
            return i_req;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one tick every i_dvsr+1 clocks.
// The divisor is captured on each reload so a change never shortens a running period.
module uart_baud_tick #(
    parameter int DVSR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DVSR_W-1:0] i_dvsr,
    output logic              o_tick
);

    logic [DVSR_W-1:0] r_cnt;
    logic [DVSR_W-1:0] r_limit;
    logic              w_tick;

    assign w_tick = (r_cnt == r_limit);
    assign o_tick = w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_limit <= '0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_limit <= i_dvsr;
        end else begin
            r_cnt   <= r_cnt + DVSR_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with error flags and a valid/ready output stage.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at every sample point.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT_MAX = 8,
    parameter int OVS      = 16,
    parameter int DVSR_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DVSR_W-1:0]   dvsr,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    input  logic                rx,
    output logic [DBIT_MAX-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                frame_err,
    output logic                parity_err,
    output logic                break_det,
    output logic                overrun,
    output logic                busy
);

    localparam int              SW    = $clog2(OVS);
    localparam logic [SW-1:0]   S_MID = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0]   S_END = SW'(OVS - 1);
    localparam logic [3:0]      DMAX  = 4'(DBIT_MAX);

    logic w_tick;

    uart_baud_tick #(
        .DVSR_W(DVSR_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dvsr(dvsr),
        .o_tick(w_tick)
    );

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    logic w_sample;

`ifdef UART_RX_MAJORITY_EN
    // r_hist holds the line as seen at the previous two ticks.
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hist <= 2'b11;
        else if (w_tick)
            r_hist <= {r_hist[0], r_sync2};
    end

    assign w_sample = (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign w_sample = r_sync2;
`endif

    state_t              r_state;
    logic [SW-1:0]       r_s;
    logic [3:0]          r_n;
    logic [DBIT_MAX-1:0] r_shift;
    logic [3:0]          r_dbits;
    logic [1:0]          r_par;
    logic                r_stop2;
    logic                r_stop_idx;
    logic                r_pbit;
    logic                r_ferr;
    logic                r_perr;
    logic                r_brk;
    logic                r_done;
    logic                r_busy;

    logic w_par_en;
    logic w_par_calc;
    logic w_ferr_final;
    logic w_brk;

    assign w_par_en     = (r_par == PAR_EVEN) || (r_par == PAR_ODD);
    assign w_par_calc   = (^r_shift) ^ w_sample;
    assign w_ferr_final = r_ferr | ~w_sample;
    assign w_brk        = w_ferr_final && (r_shift == '0) && (!w_par_en || !r_pbit);
    assign busy         = r_busy;

    // Frame sequencer; r_s counts ticks within a bit, r_n counts data bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_n        <= '0;
            r_shift    <= '0;
            r_dbits    <= DBIT_MIN;
            r_par      <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_pbit     <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_brk      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_sync2) begin
                        r_dbits    <= clamp_dbits(cfg_dbits, DMAX);
                        r_par      <= cfg_parity;
                        r_stop2    <= cfg_stop2;
                        r_s        <= '0;
                        r_n        <= '0;
                        r_shift    <= '0;
                        r_stop_idx <= 1'b0;
                        r_pbit     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_perr     <= 1'b0;
                        r_brk      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_s == S_MID) begin
                            r_s <= '0;
                            if (!w_sample) begin
                                r_state <= DATA;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_s == S_END) begin
                            r_s <= '0;
                            for (int i = 0; i < DBIT_MAX; i++)
                                if (r_n == 4'(i))
                                    r_shift[i] <= w_sample;
                            r_n <= r_n + 4'd1;
                            if (r_n == r_dbits - 4'd1)
                                r_state <= w_par_en ? PARITY : STOP;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        if (r_s == S_END) begin
                            r_s     <= '0;
                            r_pbit  <= w_sample;
                            r_perr  <= (r_par == PAR_ODD) ? ~w_par_calc : w_par_calc;
                            r_state <= STOP;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_s == S_END) begin
                            r_s <= '0;
                            if (r_stop2 && !r_stop_idx) begin
                                r_stop_idx <= 1'b1;
                                r_ferr     <= w_ferr_final;
                            end else begin
                                r_ferr  <= w_ferr_final;
                                r_brk   <= w_brk;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= w_brk ? BRK_WAIT : IDLE;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                BRK_WAIT: begin
                    if (r_sync2)
                        r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A completion while the consumer stalls drops the new frame and only records the loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (r_done) begin
            if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else begin
                rx_data    <= r_shift;
                rx_valid   <= 1'b1;
                frame_err  <= r_ferr;
                parity_err <= r_perr;
                break_det  <= r_brk;
                overrun    <= 1'b0;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg at OVS=16, dvsr=3 (64 clocks per bit).
// The glitch-rejection frame is only sent when UART_RX_MAJORITY_EN is defined.
module tb_uart_rx_cfg;

    localparam int BITCLK = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dvsr = 16'd3;
    logic [3:0]  cfg_dbits = 4'd8;
    logic [1:0]  cfg_parity = 2'd0;
    logic        cfg_stop2 = 1'b0;
    logic        rx = 1'b1;
    logic        rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        parity_err;
    logic        break_det;
    logic        overrun;
    logic        busy;

    uart_rx_cfg #(
        .DBIT_MAX(8),
        .OVS     (16),
        .DVSR_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dvsr      (dvsr),
        .cfg_dbits (cfg_dbits),
        .cfg_parity(cfg_parity),
        .cfg_stop2 (cfg_stop2),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .break_det (break_det),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       brk;
        logic       ovr;
    } exp_t;

    exp_t expQ[$];
    int   vecCount = 0;
    int   errCount = 0;

    function automatic exp_t mkExp(input logic [7:0] d, input logic fe, input logic pe,
                                   input logic brk, input logic ovr);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.pe   = pe;
        e.brk  = brk;
        e.ovr  = ovr;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops one expectation per accepted word and checks the held word stays put.
    exp_t       popped;
    logic       heldValid = 1'b0;
    logic [10:0] heldVal = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            heldValid = 1'b0;
        end else if (rx_valid && rx_ready) begin
            heldValid = 1'b0;
            if (expQ.size() == 0) begin
                checkOutput("unexpected word", 32'({rx_data, frame_err, parity_err, break_det, overrun}),
                            32'hFFFF_FFFF);
            end else begin
                popped = expQ.pop_front();
                checkOutput("rx word {data,fe,pe,brk,ovr}",
                            32'({rx_data, frame_err, parity_err, break_det, overrun}), 32'(popped));
            end
        end else if (rx_valid) begin
            if (heldValid)
                checkOutput("held word stable", 32'({rx_data, frame_err, parity_err, break_det}),
                            32'(heldVal));
            heldValid = 1'b1;
            heldVal   = {rx_data, frame_err, parity_err, break_det};
        end else begin
            heldValid = 1'b0;
        end
    end

    task automatic driveBit(input logic v, input int clocks);
        rx = v;
        repeat (clocks) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int nbits, input bit hasPar,
                                 input logic pbit, input int nStop, input logic stopVal,
                                 input bit expectWord, input exp_t e);
        if (expectWord)
            expQ.push_back(e);
        driveBit(1'b0, BITCLK);
        for (int i = 0; i < nbits; i++)
            driveBit(data[i], BITCLK);
        if (hasPar)
            driveBit(pbit, BITCLK);
        for (int s = 0; s < nStop; s++)
            driveBit(stopVal, stopVal ? BITCLK : 40);
        driveBit(1'b1, 2 * BITCLK);
    endtask

    task automatic waitBusy(input logic level, input int limit, input string name);
        int n;
        n = 0;
        while (busy !== level && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== level)
            checkOutput(name, 32'(busy), 32'(level));
    endtask

    int riseT;
    int fallT;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", 32'({rx_data, rx_valid, frame_err, parity_err, break_det, overrun, busy}),
                    32'd0);
        rst_n = 1'b1;
        driveBit(1'b1, BITCLK);

        // 8N1 basic frame
        cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, mkExp(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
        checkOutput("busy idle after 8N1", 32'(busy), 32'd0);

        // 7E1 good and bad parity, then 5O2
        cfg_dbits = 4'd7; cfg_parity = 2'd1;
        applyStimulus(8'h3C, 7, 1'b1, 1'b0, 1, 1'b1, 1'b1, mkExp(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus(8'h3C, 7, 1'b1, 1'b1, 1, 1'b1, 1'b1, mkExp(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0));
        cfg_dbits = 4'd5; cfg_parity = 2'd2; cfg_stop2 = 1'b1;
        applyStimulus(8'h15, 5, 1'b1, 1'b0, 2, 1'b1, 1'b1, mkExp(8'h15, 1'b0, 1'b0, 1'b0, 1'b0));

        // Frame error, then break
        cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        applyStimulus(8'h99, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1, mkExp(8'h99, 1'b1, 1'b0, 1'b0, 1'b0));
        expQ.push_back(mkExp(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
        driveBit(1'b0, 11 * BITCLK);
        checkOutput("busy low in break wait", 32'(busy), 32'd0);
        driveBit(1'b0, BITCLK);
        driveBit(1'b1, 2 * BITCLK);
        applyStimulus(8'h7E, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, mkExp(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0));

        // Short low pulse must be rejected as a false start
        riseT = -1;
        fallT = -1;
        rx = 1'b0;
        for (int t = 0; t < 80; t++) begin
            @(posedge clk);
            #1;
            if (t == 19)
                rx = 1'b1;
            if (busy && riseT < 0)
                riseT = t;
            if (!busy && riseT >= 0 && fallT < 0)
                fallT = t;
        end
        checkOutput("glitch raised busy", 32'(riseT >= 0), 32'd1);
        checkOutput("glitch abort within 9 ticks", 32'(fallT >= 0 && (fallT - riseT) < 36), 32'd1);
        driveBit(1'b1, BITCLK);

        // Overrun: second frame dropped while first is held
        rx_ready = 1'b0;
        applyStimulus(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, mkExp(8'h11, 1'b0, 1'b0, 1'b0, 1'b1));
        applyStimulus(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, mkExp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        checkOutput("overrun flagged {valid,ovr,data}", 32'({rx_valid, overrun, rx_data}), 32'h311);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("overrun cleared {valid,ovr}", 32'({rx_valid, overrun}), 32'd0);

        // Handshake coinciding with completion loads the new word without overrun
        rx_ready = 1'b0;
        applyStimulus(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, mkExp(8'h11, 1'b0, 1'b0, 1'b0, 1'b0));
        fork
            applyStimulus(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, mkExp(8'h22, 1'b0, 1'b0, 1'b0, 1'b0));
            begin
                waitBusy(1'b1, 4 * BITCLK, "busy rise for 0x22");
                waitBusy(1'b0, 12 * BITCLK, "busy fall for 0x22");
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        checkOutput("same-cycle load {valid,ovr,data}", 32'({rx_valid, overrun, rx_data}), 32'h222);
        rx_ready = 1'b1;
        driveBit(1'b1, 4);

        // Reset in the middle of a data phase
        driveBit(1'b0, BITCLK);
        driveBit(1'b1, BITCLK);
        driveBit(1'b1, BITCLK);
        driveBit(1'b0, BITCLK / 2);
        checkOutput("busy during data", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("outputs in mid-frame reset",
                    32'({rx_data, rx_valid, frame_err, parity_err, break_det, overrun, busy}), 32'd0);
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        driveBit(1'b1, BITCLK);
        applyStimulus(8'h7E, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, mkExp(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0));

`ifdef UART_RX_MAJORITY_EN
        // One-tick inversion inside every data bit is voted out
        expQ.push_back(mkExp(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
        driveBit(1'b0, BITCLK);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'hA5;
            driveBit(pat[i], 32);
            driveBit(~pat[i], 4);
            driveBit(pat[i], BITCLK - 36);
        end
        driveBit(1'b1, 3 * BITCLK);
`endif

        driveBit(1'b1, 2 * BITCLK);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #2000000;
        errCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Runtime-configurable UART receiver, successor to the fixed 8-bit receiver inside uart_top.
- Has its own oversampling tick generator.
- Frame format selected at run time: 5..DBIT_MAX data bits, none/even/odd parity, 1 or 2 stop bits.
- Detects and reports frame, parity and break errors and overrun; delivers words over a valid/ready handshake into the RX FIFO or a bus bridge.

Parameters:
- DBIT_MAX, 8, maximum data bits per frame and width of rx_data; legal range 5..9.
- OVS, 16, oversampling ticks per bit; power of two, >= 8.
- DVSR_W, 16, width of the dvsr port.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- dvsr  in  DVSR_W  tick divisor; one tick every dvsr+1 clocks (dvsr=0 gives a tick every clock).
- cfg_dbits  in  4  data bits per frame; clamped to 5..DBIT_MAX.
- cfg_parity  in  2  0 = none, 1 = even, 2 = odd, 3 = none.
- cfg_stop2  in  1  1 = two stop bits.
- rx  in  1  serial line, asynchronous, idle high.
- rx_data  out  DBIT_MAX  received word, right-justified, unused MSBs zero.
- rx_valid  out  1  word and flags are held valid.
- rx_ready  in  1  consumer accepts the word.
- frame_err  out  1  held word had a stop bit sampled 0.
- parity_err  out  1  held word failed the parity check.
- break_det  out  1  held word was a break.
- overrun  out  1  at least one frame was dropped while this word was held.
- busy  out  1  frame reception in progress.

Behaviour:
- Reset: every output is 0, FSM is IDLE, the synchroniser resets to 1, the tick counter is 0.
- Input synchronisation: rx passes through a 2-flop synchroniser; all sampling uses the synchronised value.
- Tick generator: free-running counter, tick when count == dvsr, then the counter reloads to 0. A dvsr change takes effect at the next reload.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE: synchronised rx == 0 → latch cfg_* (a mid-frame config change does not affect the current frame), clear s and n, busy = 1, go to START.
  - START: at tick with s == OVS/2-1, rx == 0 → s = 0, go to DATA; rx == 1 → glitch, go to IDLE with busy = 0 and no output.
  - DATA: at tick with s == OVS-1, shift the sample in LSB-first and increment n. After the last bit go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: at s == OVS-1 sample the parity bit. Even parity requires data XOR parity == 0; odd parity requires it == 1.
  - STOP: sample 1 or 2 stop bits at s == OVS-1. Any zero sample sets frame error.
  - STOP end: after the last stop sample, issue the completion pulse. Break = frame error with all data bits 0 and the parity bit (if enabled) 0.
  - Next state after STOP: break → BRK_WAIT; otherwise → IDLE.
  - BRK_WAIT: stay until synchronised rx == 1, then go to IDLE (no re-trigger while the line is held low).
- Output register load:
  - On completion the word and flags load the next clock; rx_valid rises one clock after the last stop-sample tick.
  - Break sets break_det = 1 and frame_err = 1.
- Handshake:
  - rx_valid & rx_ready clears rx_valid the next clock.
  - Completion while rx_valid & !rx_ready: the new frame is dropped, the held data is unchanged, overrun is set.
  - Completion in the same cycle as a handshake: the new word loads, rx_valid stays 1, no overrun.
  - overrun is cleared when its word is consumed.
  - rx_data and the flags are stable while rx_valid & !rx_ready.
- Reset mid-frame: returns to IDLE immediately; the partial frame is discarded.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample point (start validation, data, parity, stop) uses a 2-of-3 majority of samples taken at the target tick and the two preceding ticks.
- Undefined: single sample at the target tick.
- Cycle timing of state transitions and rx_valid is identical either way.

Decomposition:
- Package uart_pkg holds:
  - the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the FSM state encoding;
  - the DBIT_MIN = 5 constant;
  - the clamp function for cfg_dbits.
- Sub-module uart_baud_tick: the dvsr counter plus tick output; it is reusable by a matching TX successor.

Test Plan:
All scenarios use OVS = 16 and dvsr = 3 (64 clocks per bit).
- 8N1 0xA5, rx_ready = 1 → single rx_valid pulse, rx_data = 0xA5, all flags 0, busy low afterwards.
- 7E1 0x3C with parity bit 0 → parity_err = 0; repeat with parity bit 1 → parity_err = 1 and rx_data = 0x3C. 5O2 0x15 with correct parity → rx_data = 0x15, no errors.
- 8N1 0x99 with stop bit 0 → frame_err = 1, break_det = 0. Line held low for 12 bit times → break_det = 1, frame_err = 1, rx_data = 0x00. No further frame until rx returns high; a following 0x7E then passes.
- rx low for 20 clocks then high → no rx_valid; busy returns to 0 before 9 ticks elapse.
- Two frames 0x11, 0x22 with rx_ready = 0 → rx_data = 0x11, overrun = 1; after the handshake, overrun = 0. Second run with rx_ready asserted exactly at completion → 0x22 received, overrun = 0.
- rst_n pulsed low during DATA of 0xC3 → all outputs 0 immediately; next frame 0x7E received correctly.
- With UART_RX_MAJORITY_EN defined: a 1-tick glitch inverting each data bit mid-sample still yields 0xA5.
